multiexp_replay_ctrl: RTL and testbench

//  Input sequencer for multiexp_top. Accepts 2^i_log2_num_in {point,scalar} entries once from the host stream.

---
 rtl/multiexp_replay_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_multiexp_replay_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/multiexp_replay_ctrl.sv
// Load-once / replay-KEY_BITS-times input sequencer placed in front of multiexp_top.
// Latency: first replay beat is valid 2 clk after the final load beat is accepted, then 1 beat/clk.
// Backpressure: a registered read stage plus a 1-entry skid absorbs core stalls; the host is held off (rdy=0) outside IDLE/LOAD.
//
// Ports:
//   i_clk, i_rst                      clock, synchronous active-high reset
//   i_log2_num_in                     log2 of entry count, sampled on the first accepted load beat
//   i_host_val/_dat/_sop/_eop/_ctl    load stream in, o_host_rdy back to host
//   o_core_val/_dat/_sop/_eop/_ctl    replay stream out, i_core_rdy from multiexp_top
//   o_busy                            high from first load beat until the last replay beat is accepted
//   o_err                             sticky load-length error, cleared only by i_rst
//   o_stall_cnt                       only with MULTIEXP_REPLAY_STATS_EN defined: saturating core stall cycles
module multiexp_replay_ctrl #(
    parameter int DAT_BITS = 1024,
    parameter int KEY_BITS = 256,
    parameter int MAX_LOG2 = 10,
    parameter int CTL_BITS = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [$clog2(MAX_LOG2+1)-1:0] i_log2_num_in,
    input  logic                          i_host_val,
    output logic                          o_host_rdy,
    input  logic [DAT_BITS-1:0]           i_host_dat,
    input  logic                          i_host_sop,
    input  logic                          i_host_eop,
    input  logic [CTL_BITS-1:0]           i_host_ctl,
    output logic                          o_core_val,
    input  logic                          i_core_rdy,
    output logic [DAT_BITS-1:0]           o_core_dat,
    output logic                          o_core_sop,
    output logic                          o_core_eop,
    output logic [CTL_BITS-1:0]           o_core_ctl,
    output logic                          o_busy,
    output logic                          o_err
`ifdef MULTIEXP_REPLAY_STATS_EN
    ,
    output logic [31:0]                   o_stall_cnt
`endif
);

    localparam int LOG2_W = $clog2(MAX_LOG2 + 1);
    localparam int IDX_W  = MAX_LOG2;
    localparam int CNT_W  = MAX_LOG2 + 1;
    localparam int PASS_W = (KEY_BITS > 1) ? $clog2(KEY_BITS) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_REPLAY, ST_DONE} state_t;

    // Host sop/ctl carry nothing this block needs; entry order is positional.
    logic unused_host;
    assign unused_host = ^{i_host_sop, i_host_ctl};

    state_t                state_q, state_d;
    logic                  host_rdy_q, host_rdy_d;
    logic                  busy_q, busy_d;
    logic                  err_q, err_d;
    logic [IDX_W-1:0]      n_last_q, n_last_d;
    logic [IDX_W-1:0]      wr_idx_q, wr_idx_d;
    logic [CNT_W-1:0]      fill_cnt_q, fill_cnt_d;
    logic [IDX_W-1:0]      rd_idx_q, rd_idx_d;
    logic [PASS_W-1:0]     pass_q, pass_d;
    logic                  rd_done_q, rd_done_d;

    // Read stage: holds the beat whose data sits in ram_q.
    logic                  r_vld_q, r_vld_d;
    logic                  r_zero_q, r_zero_d;
    logic                  r_sop_q, r_sop_d;
    logic                  r_eop_q, r_eop_d;
    logic                  r_last_q, r_last_d;
    logic [CTL_BITS-1:0]   r_ctl_q, r_ctl_d;

    // Skid: holds the older beat when a read lands while the output is stalled.
    logic                  sk_vld_q, sk_vld_d;
    logic [DAT_BITS-1:0]   sk_dat_q, sk_dat_d;
    logic                  sk_sop_q, sk_sop_d;
    logic                  sk_eop_q, sk_eop_d;
    logic                  sk_last_q, sk_last_d;
    logic [CTL_BITS-1:0]   sk_ctl_q, sk_ctl_d;

    logic [DAT_BITS-1:0]   ram [0:(1<<MAX_LOG2)-1];
    logic [DAT_BITS-1:0]   ram_q;

    logic                  accept;
    logic                  issue;
    logic                  out_vld;
    logic                  out_last;
    logic                  xfer;
    logic [IDX_W-1:0]      wr_ptr;
    logic [IDX_W-1:0]      n_last_in;
    logic [IDX_W-1:0]      n_last_cur;
    logic [LOG2_W-1:0]     log2_clamp;
    logic [CNT_W-1:0]      n_full;
    logic [DAT_BITS-1:0]   r_dat;

    assign log2_clamp = (i_log2_num_in > LOG2_W'(MAX_LOG2)) ? LOG2_W'(MAX_LOG2) : i_log2_num_in;
    assign n_full     = (CNT_W'(1) << log2_clamp) - CNT_W'(1);
    assign n_last_in  = n_full[IDX_W-1:0];

    assign accept     = host_rdy_q && i_host_val;
    assign wr_ptr     = (state_q == ST_IDLE) ? '0 : wr_idx_q;
    assign n_last_cur = (state_q == ST_IDLE) ? n_last_in : n_last_q;

    // Entries never written because of an early eop read back as zero.
    assign r_dat    = r_zero_q ? '0 : ram_q;
    assign out_vld  = sk_vld_q || r_vld_q;
    assign out_last = sk_vld_q ? sk_last_q : r_last_q;
    assign xfer     = out_vld && i_core_rdy;
    // Issue depends only on registered state, so core rdy never reaches the RAM address path.
    assign issue    = (state_q == ST_REPLAY) && !rd_done_q && !sk_vld_q;

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        err_d      = err_q;
        n_last_d   = n_last_q;
        wr_idx_d   = wr_idx_q;
        fill_cnt_d = fill_cnt_q;
        rd_idx_d   = rd_idx_q;
        pass_d     = pass_q;
        rd_done_d  = rd_done_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    n_last_d = n_last_in;
                    busy_d   = 1'b1;
                    state_d  = ST_LOAD;
                end
            end
            ST_REPLAY: begin
                if (xfer && out_last) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: ;
        endcase

        // Shared by the IDLE first beat and LOAD beats.
        if (accept) begin
            wr_idx_d   = wr_ptr + IDX_W'(1);
            fill_cnt_d = {1'b0, wr_ptr} + CNT_W'(1);
            if ((wr_ptr == n_last_cur) || i_host_eop) begin
                state_d   = ST_REPLAY;
                rd_idx_d  = '0;
                pass_d    = PASS_W'(KEY_BITS - 1);
                rd_done_d = 1'b0;
                if ((wr_ptr == n_last_cur) != i_host_eop) begin
                    err_d = 1'b1;
                end
            end
        end

        if (issue) begin
            if (rd_idx_q == n_last_q) begin
                rd_idx_d = '0;
                if (pass_q == '0) begin
                    rd_done_d = 1'b1;
                end else begin
                    pass_d = pass_q - PASS_W'(1);
                end
            end else begin
                rd_idx_d = rd_idx_q + IDX_W'(1);
            end
        end

        host_rdy_d = (state_d == ST_IDLE) || (state_d == ST_LOAD);
    end

    always_comb begin
        r_vld_d   = r_vld_q;
        r_zero_d  = r_zero_q;
        r_sop_d   = r_sop_q;
        r_eop_d   = r_eop_q;
        r_last_d  = r_last_q;
        r_ctl_d   = r_ctl_q;
        sk_vld_d  = sk_vld_q;
        sk_dat_d  = sk_dat_q;
        sk_sop_d  = sk_sop_q;
        sk_eop_d  = sk_eop_q;
        sk_last_d = sk_last_q;
        sk_ctl_d  = sk_ctl_q;

        if (issue) begin
            r_vld_d  = 1'b1;
            r_zero_d = {1'b0, rd_idx_q} >= fill_cnt_q;
            r_sop_d  = (rd_idx_q == '0);
            r_eop_d  = (rd_idx_q == n_last_q);
            r_last_d = (rd_idx_q == n_last_q) && (pass_q == '0);
            r_ctl_d  = CTL_BITS'(pass_q);
        end else if (xfer && !sk_vld_q) begin
            r_vld_d = 1'b0;
        end

        if (sk_vld_q) begin
            if (xfer) begin
                sk_vld_d = 1'b0;
            end
        end else if (issue && r_vld_q && !xfer) begin
            // New read overwrites ram_q: park the stalled beat first.
            sk_vld_d  = 1'b1;
            sk_dat_d  = r_dat;
            sk_sop_d  = r_sop_q;
            sk_eop_d  = r_eop_q;
            sk_last_d = r_last_q;
            sk_ctl_d  = r_ctl_q;
        end
    end

    // Entry RAM: no reset, contents are don't-care after an abort.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            ram[wr_ptr] <= i_host_dat;
        end
        if (issue) begin
            ram_q <= ram[rd_idx_q];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            host_rdy_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            n_last_q   <= '0;
            wr_idx_q   <= '0;
            fill_cnt_q <= '0;
            rd_idx_q   <= '0;
            pass_q     <= '0;
            rd_done_q  <= 1'b0;
            r_vld_q    <= 1'b0;
            r_zero_q   <= 1'b0;
            r_sop_q    <= 1'b0;
            r_eop_q    <= 1'b0;
            r_last_q   <= 1'b0;
            r_ctl_q    <= '0;
            sk_vld_q   <= 1'b0;
            sk_dat_q   <= '0;
            sk_sop_q   <= 1'b0;
            sk_eop_q   <= 1'b0;
            sk_last_q  <= 1'b0;
            sk_ctl_q   <= '0;
        end else begin
            state_q    <= state_d;
            host_rdy_q <= host_rdy_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            n_last_q   <= n_last_d;
            wr_idx_q   <= wr_idx_d;
            fill_cnt_q <= fill_cnt_d;
            rd_idx_q   <= rd_idx_d;
            pass_q     <= pass_d;
            rd_done_q  <= rd_done_d;
            r_vld_q    <= r_vld_d;
            r_zero_q   <= r_zero_d;
            r_sop_q    <= r_sop_d;
            r_eop_q    <= r_eop_d;
            r_last_q   <= r_last_d;
            r_ctl_q    <= r_ctl_d;
            sk_vld_q   <= sk_vld_d;
            sk_dat_q   <= sk_dat_d;
            sk_sop_q   <= sk_sop_d;
            sk_eop_q   <= sk_eop_d;
            sk_last_q  <= sk_last_d;
            sk_ctl_q   <= sk_ctl_d;
        end
    end

    assign o_host_rdy = host_rdy_q;
    assign o_core_val = out_vld;
    assign o_core_dat = sk_vld_q ? sk_dat_q  : (r_vld_q ? r_dat : '0);
    assign o_core_sop = sk_vld_q ? sk_sop_q  : (r_vld_q && r_sop_q);
    assign o_core_eop = sk_vld_q ? sk_eop_q  : (r_vld_q && r_eop_q);
    assign o_core_ctl = sk_vld_q ? sk_ctl_q  : (r_vld_q ? r_ctl_q : '0);
    assign o_busy     = busy_q;
    assign o_err      = err_q;

`ifdef MULTIEXP_REPLAY_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Cleared at every job start, which covers IDLE->LOAD (and IDLE->REPLAY for N==1).
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == ST_IDLE) && accept) begin
            stall_cnt_d = '0;
        end else if ((state_q == ST_REPLAY) && out_vld && !i_core_rdy &&
                     (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_multiexp_replay_ctrl.sv
module tb_multiexp_replay_ctrl;

    localparam int DAT_BITS = 32;
    localparam int KEY_BITS = 128;
    localparam int MAX_LOG2 = 4;
    localparam int CTL_BITS = 8;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [2:0]          log2_num = '0;
    logic                host_val = 1'b0;
    logic                host_rdy;
    logic [DAT_BITS-1:0] host_dat = '0;
    logic                host_sop = 1'b0;
    logic                host_eop = 1'b0;
    logic [CTL_BITS-1:0] host_ctl = '0;
    logic                core_val;
    logic                core_rdy = 1'b0;
    logic [DAT_BITS-1:0] core_dat;
    logic                core_sop;
    logic                core_eop;
    logic [CTL_BITS-1:0] core_ctl;
    logic                busy;
    logic                err;
`ifdef MULTIEXP_REPLAY_STATS_EN
    logic [31:0]         stall_cnt;
`endif

    int tests = 0;
    int fails = 0;
    int tb_stalls;

    always #5 clk = ~clk;

    multiexp_replay_ctrl #(
        .DAT_BITS(DAT_BITS), .KEY_BITS(KEY_BITS), .MAX_LOG2(MAX_LOG2), .CTL_BITS(CTL_BITS)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_log2_num_in(log2_num),
        .i_host_val(host_val), .o_host_rdy(host_rdy), .i_host_dat(host_dat),
        .i_host_sop(host_sop), .i_host_eop(host_eop), .i_host_ctl(host_ctl),
        .o_core_val(core_val), .i_core_rdy(core_rdy), .o_core_dat(core_dat),
        .o_core_sop(core_sop), .o_core_eop(core_eop), .o_core_ctl(core_ctl),
        .o_busy(busy), .o_err(err)
`ifdef MULTIEXP_REPLAY_STATS_EN
        , .o_stall_cnt(stall_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge: outputs settled, inputs set for the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ent(input int job, input int k);
        return 32'h5A00_0000 | (32'(job) << 16) | 32'(k + 1);
    endfunction

    // Sends nsend beats, eop on beat eop_at (-1 = never), then checks the 2-clk first-beat latency.
    task automatic load_job(input int job, input int log2, input int nsend, input int eop_at);
        int max_wait = 0;
        log2_num = 3'(log2);
        for (int k = 0; k < nsend; k++) begin
            int w = 0;
            host_val = 1'b1;
            host_dat = ent(job, k);
            host_sop = (k == 0);
            host_eop = (k == eop_at);
            while (!host_rdy && w < 50) begin
                step();
                w++;
            end
            if (w > max_wait) max_wait = w;
            step();
        end
        host_val = 1'b0;
        host_sop = 1'b0;
        host_eop = 1'b0;
        chk($sformatf("job%0d_load_rdy_wait_ok", job), 64'(max_wait < 50), 64'd1);
        chk($sformatf("job%0d_rdy_drop", job), 64'(host_rdy), 64'd0);
        chk($sformatf("job%0d_val_t1", job), 64'(core_val), 64'd0);
        step();
        chk($sformatf("job%0d_val_t2", job), 64'(core_val), 64'd1);
        chk($sformatf("job%0d_busy_replay", job), 64'(busy), 64'd1);
    endtask

    // Consumes n*KEY_BITS beats and checks order/content, stall stability and the end-of-job sequence.
    task automatic collect(input int job, input int n, input int fill, input bit rnd);
        int got = 0, mism = 0, viol = 0, cyc = 0, first_bad = -1;
        int total = n * KEY_BITS;
        bit held_v = 0;
        logic [DAT_BITS-1:0] h_dat;
        logic [CTL_BITS-1:0] h_ctl;
        logic h_sop, h_eop;
        tb_stalls = 0;
        while (got < total && cyc < total * 8 + 100) begin
            if (held_v) begin
                if (!(core_val && core_dat === h_dat && core_ctl === h_ctl &&
                      core_sop === h_sop && core_eop === h_eop)) viol++;
            end
            core_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (core_val && core_rdy) begin
                int p = KEY_BITS - 1 - got / n;
                int idx = got % n;
                logic [DAT_BITS-1:0] e_dat = (idx < fill) ? ent(job, idx) : '0;
                if (core_dat !== e_dat || core_ctl !== 8'(p) ||
                    core_sop !== (idx == 0) || core_eop !== (idx == n - 1)) begin
                    mism++;
                    if (first_bad < 0) first_bad = got;
                end
                got++;
                held_v = 0;
            end else if (core_val) begin
                held_v = 1;
                h_dat = core_dat; h_ctl = core_ctl; h_sop = core_sop; h_eop = core_eop;
                tb_stalls++;
            end else begin
                held_v = 0;
            end
            step();
            cyc++;
        end
        core_rdy = 1'b0;
        chk($sformatf("job%0d_beat_count", job), 64'(got), 64'(total));
        chk($sformatf("job%0d_beat_mismatch(first_bad=%0d)", job, first_bad), 64'(mism), 64'd0);
        chk($sformatf("job%0d_stall_stable", job), 64'(viol), 64'd0);
`ifdef MULTIEXP_REPLAY_STATS_EN
        chk($sformatf("job%0d_stall_cnt", job), 64'(stall_cnt), 64'(tb_stalls));
`endif
        chk($sformatf("job%0d_busy_low_after_last", job), 64'(busy), 64'd0);
        chk($sformatf("job%0d_no_extra_beat", job), 64'(core_val), 64'd0);
        chk($sformatf("job%0d_rdy_low_in_done", job), 64'(host_rdy), 64'd0);
        step();
        chk($sformatf("job%0d_rdy_back", job), 64'(host_rdy), 64'd1);
        chk($sformatf("job%0d_no_extra_beat2", job), 64'(core_val), 64'd0);
    endtask

    initial begin
        bit found;
        int w;

        // Reset state
        rst = 1'b1;
        step(); step(); step();
        chk("rst_host_rdy", 64'(host_rdy), 64'd0);
        chk("rst_core_val", 64'(core_val), 64'd0);
        chk("rst_core_sop", 64'(core_sop), 64'd0);
        chk("rst_core_eop", 64'(core_eop), 64'd0);
        chk("rst_core_ctl", 64'(core_ctl), 64'd0);
        chk("rst_core_dat", 64'(core_dat), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        rst = 1'b0;
        step();
        chk("idle_host_rdy", 64'(host_rdy), 64'd1);

        // 1: four entries, core always ready
        load_job(1, 2, 4, 3);
        collect(1, 4, 4, 1'b0);
        chk("job1_err", 64'(err), 64'd0);

        // 2: same with random core backpressure
        load_job(2, 2, 4, 3);
        collect(2, 4, 4, 1'b1);

        // 3: single entry
        load_job(3, 0, 1, 0);
        collect(3, 1, 1, 1'b0);
        chk("job3_err", 64'(err), 64'd0);

        // 4: eop on third entry of four -> error, last entry zero
        load_job(4, 2, 3, 2);
        chk("job4_err_set", 64'(err), 64'd1);
        collect(4, 4, 3, 1'b0);
        chk("job4_err_sticky", 64'(err), 64'd1);

        // 5: reset in the middle of replay, then a clean job
        load_job(5, 2, 4, 3);
        core_rdy = 1'b1;
        found = 0;
        w = 0;
        while (!found && w < 2000) begin
            if (core_val && core_ctl == 8'd100) found = 1;
            else begin
                step();
                w++;
            end
        end
        chk("job5_reached_pass100", 64'(found), 64'd1);
        chk("job5_busy_before_rst", 64'(busy), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        core_rdy = 1'b0;
        chk("job5_val_after_rst", 64'(core_val), 64'd0);
        chk("job5_busy_after_rst", 64'(busy), 64'd0);
        chk("job5_err_cleared", 64'(err), 64'd0);
        chk("job5_rdy_after_rst", 64'(host_rdy), 64'd0);
        step();
        chk("job5_rdy_back", 64'(host_rdy), 64'd1);
        load_job(6, 2, 4, 3);
        collect(6, 4, 4, 1'b1);
        chk("job6_err", 64'(err), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
